// File: rtl/graph_pkg.sv
// Shared graph constants and types for the search and backtrace stages.
//   N_NODE     : number of graph nodes (power of two)
//   IDX_W      : node index width, log2(N_NODE)
//   node_idx_t : node index type
//   bt_state_t : backtrace FSM state
package graph_pkg;

  localparam int unsigned N_NODE = 64;
  localparam int unsigned IDX_W  = $clog2(N_NODE);

  typedef logic [IDX_W-1:0] node_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    FIN  = 2'd2
  } bt_state_t;

endpackage

// File: rtl/pred_lut.sv
// Predecessor snapshot table with an N_NODE:1 read mux.
//   CLK, RST_n : clock, async active-low reset
//   load       : capture pred_flat into the snapshot
//   pred_flat  : predecessor of node i at bits [i*IDX_W +: IDX_W]
//   rd_idx     : node to look up
//   rd_pred_c  : combinational predecessor of rd_idx from the snapshot
module pred_lut
  import graph_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      load,
  input  logic [N_NODE*IDX_W-1:0]   pred_flat,
  input  node_idx_t                 rd_idx,
  output node_idx_t                 rd_pred_c
);

  node_idx_t pred_q [N_NODE];

  // Snapshot register array
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < int'(N_NODE); i++) begin
        pred_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < int'(N_NODE); i++) begin
        pred_q[i] <= pred_flat[i*IDX_W +: IDX_W];
      end
    end
  end

  // Predecessor lookup for the walk pointer
  assign rd_pred_c = pred_q[rd_idx];

endmodule

// File: rtl/route_backtrace.sv
// Walks the predecessor snapshot from endPoint back to startPoint and streams
// route nodes (endpoint first) over valid/ready, then pulses route_done.
//   CLK, RST_n            : clock, async active-low reset
//   search_done           : pulse; reached/pred_flat/startPoint/endPoint valid
//   reached, pred_flat    : search results
//   startPoint, endPoint  : route source / destination
//   node_valid/ready/idx  : route node stream, node_last marks startPoint
//   busy                  : walk in progress (WALK or FIN)
//   route_done, route_ok  : end-of-walk pulse and success flag
//   hop_count             : hops walked, held until the next walk ends
module route_backtrace
  import graph_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      search_done,
  input  logic [N_NODE-1:0]         reached,
  input  logic [N_NODE*IDX_W-1:0]   pred_flat,
  input  logic [IDX_W-1:0]          startPoint,
  input  logic [IDX_W-1:0]          endPoint,
  output logic                      node_valid,
  input  logic                      node_ready,
  output logic [IDX_W-1:0]          node_idx,
  output logic                      node_last,
  output logic                      busy,
  output logic                      route_done,
  output logic                      route_ok,
  output logic [IDX_W-1:0]          hop_count
);

  localparam node_idx_t HOP_MAX = IDX_W'(N_NODE - 1);

  bt_state_t state_q, state_d;
  node_idx_t cur_q, cur_d;
  node_idx_t start_q, start_d;
  node_idx_t hops_q, hops_d;
  node_idx_t hop_count_q, hop_count_d;
  logic      valid_q, valid_d;
  logic      last_q, last_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      ok_q, ok_d;
  logic      load_c;
  node_idx_t pred_cur_c;

  pred_lut u_pred_lut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .load      (load_c),
    .pred_flat (pred_flat),
    .rd_idx    (cur_q),
    .rd_pred_c (pred_cur_c)
  );

  // State and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      start_q     <= '0;
      hops_q      <= '0;
      hop_count_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      start_q     <= start_d;
      hops_q      <= hops_d;
      hop_count_q <= hop_count_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    start_d     = start_q;
    hops_d      = hops_q;
    hop_count_d = hop_count_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    load_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (search_done) begin
          load_c  = 1'b1;
          start_d = startPoint;
          cur_d   = endPoint;
          hops_d  = '0;
          if (reached[endPoint]) begin
            state_d = WALK;
            valid_d = 1'b1;
            last_d  = (endPoint == startPoint);
          end else begin
            state_d     = FIN;
            done_d      = 1'b1;
            hop_count_d = '0;
          end
        end
      end

      WALK: begin
        if (valid_q && node_ready) begin
          if (last_q) begin
            state_d     = FIN;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            done_d      = 1'b1;
            ok_d        = 1'b1;
            hop_count_d = hops_q;
          end else if (hops_q == HOP_MAX) begin
            // Loop guard: predecessor table never reached startPoint
            state_d     = FIN;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            done_d      = 1'b1;
            hop_count_d = hops_q;
          end else begin
            cur_d  = pred_cur_c;
            last_d = (pred_cur_c == start_q);
            hops_d = hops_q + IDX_W'(1);
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign node_valid = valid_q;
  assign node_idx   = cur_q;
  assign node_last  = last_q;
  assign busy       = busy_q;
  assign route_done = done_q;
  assign route_ok   = ok_q;
  assign hop_count  = hop_count_q;

endmodule

// File: tb/tb_route_backtrace.sv
// Bench for route_backtrace: table of walk scenarios with a beat scoreboard,
// plus hand sequences for reset and mid-walk abort.
module tb_route_backtrace;
  import graph_pkg::*;

  localparam int CHAIN = 0;
  localparam int CYCLE = 1;
  localparam int BUDGET = 400;

  logic                    CLK;
  logic                    RST_n;
  logic                    search_done;
  logic [N_NODE-1:0]       reached;
  logic [N_NODE*IDX_W-1:0] pred_flat;
  logic [IDX_W-1:0]        startPoint;
  logic [IDX_W-1:0]        endPoint;
  logic                    node_valid;
  logic                    node_ready;
  logic [IDX_W-1:0]        node_idx;
  logic                    node_last;
  logic                    busy;
  logic                    route_done;
  logic                    route_ok;
  logic [IDX_W-1:0]        hop_count;

  route_backtrace dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .search_done (search_done),
    .reached     (reached),
    .pred_flat   (pred_flat),
    .startPoint  (startPoint),
    .endPoint    (endPoint),
    .node_valid  (node_valid),
    .node_ready  (node_ready),
    .node_idx    (node_idx),
    .node_last   (node_last),
    .busy        (busy),
    .route_done  (route_done),
    .route_ok    (route_ok),
    .hop_count   (hop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int start;
    int endp;
    bit reach;
    int kind;
    int mode;      // 0 ready high, 1 pattern 1,0,0, 2 random
    int inj;       // cycle of an extra search_done (0 = none)
    bit exp_ok;
    int exp_hops;
  } vec_t;

  typedef struct {
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vt[9];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [N_NODE*IDX_W-1:0] rand_flat();
    logic [N_NODE*IDX_W-1:0] f;
    for (int i = 0; i < int'(N_NODE); i++) f[i*IDX_W +: IDX_W] = IDX_W'($urandom);
    return f;
  endfunction

  task automatic run_vec(input vec_t v);
    int pa[N_NODE];
    logic [N_NODE-1:0] rm;
    logic [N_NODE*IDX_W-1:0] pf;
    int cur, h, n, stall_idx;
    bit done, stall, stall_last, rdy;
    beat_t b;

    for (int i = 0; i < int'(N_NODE); i++) pa[i] = (i == 0) ? 0 : i - 1;
    if (v.kind == CYCLE) begin
      pa[7] = 8;
      pa[8] = 7;
    end
    rm = '1;
    if (!v.reach) rm[v.endp] = 1'b0;
    for (int i = 0; i < int'(N_NODE); i++) pf[i*IDX_W +: IDX_W] = IDX_W'(pa[i]);

    // Reference walk: expected beats into the scoreboard
    exp_q.delete();
    if (v.reach) begin
      cur = v.endp;
      h = 0;
      forever begin
        b.idx  = cur;
        b.last = (cur == v.start);
        exp_q.push_back(b);
        if (b.last || h == int'(N_NODE) - 1) break;
        cur = pa[cur];
        h++;
      end
    end

    @(posedge CLK); #1;
    search_done = 1'b1;
    reached     = rm;
    pred_flat   = pf;
    startPoint  = IDX_W'(v.start);
    endPoint    = IDX_W'(v.endp);
    node_ready  = 1'b0;
    @(posedge CLK); #1;
    // Scramble inputs: the snapshot must be the only source now
    pred_flat  = rand_flat();
    reached    = {$urandom, $urandom};
    startPoint = IDX_W'($urandom);
    endPoint   = IDX_W'($urandom);

    n = 1;
    done = 0;
    stall = 0;
    stall_idx = 0;
    stall_last = 0;
    while (!done && n < BUDGET) begin
      search_done = (n == v.inj);
      case (v.mode)
        0: rdy = 1'b1;
        1: rdy = ((n - 1) % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      node_ready = rdy;
      if (stall) begin
        chk("stall_valid", int'(node_valid), 1);
        chk("stall_idx", int'(node_idx), stall_idx);
        chk("stall_last", int'(node_last), int'(stall_last));
      end
      stall = 0;
      if (node_valid) begin
        chk("busy_walk", int'(busy), 1);
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", int'(node_idx), -1);
          end else begin
            b = exp_q.pop_front();
            chk("beat_idx", int'(node_idx), b.idx);
            chk("beat_last", int'(node_last), int'(b.last));
          end
        end else begin
          stall = 1;
          stall_idx = int'(node_idx);
          stall_last = node_last;
        end
      end
      if (route_done) begin
        chk("route_ok", int'(route_ok), int'(v.exp_ok));
        chk("hop_count", int'(hop_count), v.exp_hops);
        chk("busy_fin", int'(busy), 1);
        chk("beats_left", exp_q.size(), 0);
        if (v.mode == 0) chk("done_latency", n, v.reach ? v.exp_hops + 2 : 1);
        done = 1;
      end
      @(posedge CLK); #1;
      n++;
    end
    search_done = 1'b0;
    node_ready  = 1'b0;
    if (!done) chk("done_timeout", n, -1);
    chk("done_pulse_end", int'(route_done), 0);
    chk("busy_end", int'(busy), 0);
    chk("hop_hold", int'(hop_count), v.exp_hops);
  endtask

  initial begin
    vt[0] = '{start: 0, endp: 3,  reach: 1, kind: CHAIN, mode: 0, inj: 0, exp_ok: 1, exp_hops: 3};
    vt[1] = '{start: 0, endp: 3,  reach: 1, kind: CHAIN, mode: 1, inj: 0, exp_ok: 1, exp_hops: 3};
    vt[2] = '{start: 0, endp: 3,  reach: 0, kind: CHAIN, mode: 0, inj: 0, exp_ok: 0, exp_hops: 0};
    vt[3] = '{start: 5, endp: 5,  reach: 1, kind: CHAIN, mode: 0, inj: 0, exp_ok: 1, exp_hops: 0};
    vt[4] = '{start: 0, endp: 7,  reach: 1, kind: CYCLE, mode: 0, inj: 0, exp_ok: 0, exp_hops: 63};
    vt[5] = '{start: 1, endp: 3,  reach: 1, kind: CHAIN, mode: 2, inj: 0, exp_ok: 1, exp_hops: 2};
    vt[6] = '{start: 0, endp: 63, reach: 1, kind: CHAIN, mode: 2, inj: 0, exp_ok: 1, exp_hops: 63};
    vt[7] = '{start: 0, endp: 3,  reach: 1, kind: CHAIN, mode: 0, inj: 2, exp_ok: 1, exp_hops: 3};
    vt[8] = '{start: 0, endp: 7,  reach: 1, kind: CYCLE, mode: 1, inj: 0, exp_ok: 0, exp_hops: 63};

    RST_n       = 1'b0;
    search_done = 1'b0;
    reached     = '0;
    pred_flat   = '0;
    startPoint  = '0;
    endPoint    = '0;
    node_ready  = 1'b0;
    #12;
    chk("rst_valid", int'(node_valid), 0);
    chk("rst_idx", int'(node_idx), 0);
    chk("rst_last", int'(node_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(route_done), 0);
    chk("rst_ok", int'(route_ok), 0);
    chk("rst_hops", int'(hop_count), 0);
    RST_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Reset mid-walk: abort at once, no route_done, then a clean walk
    @(posedge CLK); #1;
    search_done = 1'b1;
    reached     = '1;
    for (int i = 0; i < int'(N_NODE); i++) pred_flat[i*IDX_W +: IDX_W] = IDX_W'((i == 0) ? 0 : i - 1);
    startPoint  = 6'd0;
    endPoint    = 6'd10;
    node_ready  = 1'b1;
    @(posedge CLK); #1;
    search_done = 1'b0;
    @(posedge CLK); #1;
    chk("pre_abort_valid", int'(node_valid), 1);
    chk("pre_abort_idx", int'(node_idx), 9);
    #2;
    RST_n = 1'b0;
    #1;
    chk("abort_valid", int'(node_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_idx", int'(node_idx), 0);
    chk("abort_hops", int'(hop_count), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("abort_no_done", int'(route_done), 0);
    end
    RST_n = 1'b1;
    node_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("post_abort_done", int'(route_done), 0);
      chk("post_abort_busy", int'(busy), 0);
    end
    run_vec(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
